// File: rtl/core_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package core_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_MEM = 2'd1,
    GNT_IF  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating bus-wait counter with a sticky timeout flag.
// The count restarts at every grant entry; the flag survives until reset.
module arb_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout_err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout_err;

  // Next count: clear wins, otherwise count wait cycles up to the ceiling.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Counter register and sticky flag; the flag sets on the edge the count reaches the ceiling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (i_en && !i_clr && (w_cnt_nxt == CNT_MAX)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the MEM stage.
// Each pipeline step serves MEM first (older instruction), then IF, and
// holds the pipeline via stall_pipe until every access of the step is done.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | arbitration cycle, bus idle
// GNT_MEM | bus granted to the load/store latched from EX/MEM
// GNT_IF  | bus granted to the instruction fetch latched from the PC
module mem_port_arbiter #(
  parameter int ADDR_W   = core_pkg::ADDR_W,
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  mem_r_in,
  input  logic                  mem_w_in,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ready,
  output logic                  stall_pipe,
  output logic                  timeout_err
);

  import core_pkg::*;

  localparam int BYTE_LANES = DATA_W / 8;

  arb_state_e              r_state;
  logic                    r_bus_req;
  logic                    r_bus_we;
  logic [ADDR_W-1:0]       r_bus_addr;
  logic [DATA_W-1:0]       r_bus_wdata;
  logic [BYTE_LANES-1:0]   r_bus_wstrb;

  logic                    r_mem_srv;
  logic                    r_if_srv;
  logic [DATA_W-1:0]       r_mem_rdata_q;
  logic [DATA_W-1:0]       r_if_rdata_q;

  logic                    w_mreq;
  logic                    w_mem_pend;
  logic                    w_if_pend;
  logic                    w_mfin;
  logic                    w_ifin;
  logic                    w_stall;
  logic                    w_grant_entry;
  logic                    w_wait;

  // Request decode and completion strobes.
  always_comb begin
    w_mreq        = mem_r_in | mem_w_in;
    w_mem_pend    = w_mreq & ~r_mem_srv;
    w_if_pend     = if_req & ~r_if_srv;
    w_mfin        = (r_state == GNT_MEM) & bus_ready;
    w_ifin        = (r_state == GNT_IF) & bus_ready;
    w_stall       = (w_mreq & ~(r_mem_srv | w_mfin)) |
                    (if_req & ~(r_if_srv | w_ifin));
    // A new grant starts either from IDLE or back-to-back after MEM completes.
    w_grant_entry = ((r_state == IDLE) & (w_mem_pend | w_if_pend)) |
                    (w_mfin & w_if_pend);
    w_wait        = (r_state != IDLE) & ~bus_ready;
  end

  // Arbitration FSM; the bus command is latched on grant entry and held for the whole grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_pend) begin
            r_state     <= GNT_MEM;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_w_in;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_w_in ? mem_wdata : '0;
            r_bus_wstrb <= mem_w_in ? mem_wstrb : '0;
          end else if (w_if_pend) begin
            r_state     <= GNT_IF;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
          end
        end
        GNT_MEM: begin
          if (bus_ready) begin
            if (w_if_pend) begin
              r_state     <= GNT_IF;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= if_addr;
              r_bus_wdata <= '0;
              r_bus_wstrb <= '0;
            end else begin
              r_state     <= IDLE;
              r_bus_req   <= 1'b0;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= '0;
              r_bus_wdata <= '0;
              r_bus_wstrb <= '0;
            end
          end
        end
        GNT_IF: begin
          if (bus_ready) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_bus_req   <= 1'b0;
          r_bus_we    <= 1'b0;
          r_bus_addr  <= '0;
          r_bus_wdata <= '0;
          r_bus_wstrb <= '0;
        end
      endcase
    end
  end

  // Served flags remember completed accesses until the pipeline advances; read data is held for the next step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_srv     <= 1'b0;
      r_if_srv      <= 1'b0;
      r_mem_rdata_q <= '0;
      r_if_rdata_q  <= '0;
    end else begin
      if (w_stall) begin
        if (w_mfin) r_mem_srv <= 1'b1;
        if (w_ifin) r_if_srv  <= 1'b1;
      end else begin
        r_mem_srv <= 1'b0;
        r_if_srv  <= 1'b0;
      end
      if (w_mfin && !r_bus_we) r_mem_rdata_q <= bus_rdata;
      if (w_ifin)              r_if_rdata_q  <= bus_rdata;
    end
  end

  arb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_grant_entry),
    .i_en          (w_wait),
    .o_timeout_err (timeout_err)
  );

  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;
  assign stall_pipe = w_stall;
  // Completing data bypasses the hold register so the pipeline can take it on the same edge.
  assign mem_rdata  = w_mfin ? bus_rdata : r_mem_rdata_q;
  assign if_rdata   = w_ifin ? bus_rdata : r_if_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_r_in;
  logic        mem_w_in;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        stall_pipe;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .mem_r_in    (mem_r_in),
    .mem_w_in    (mem_w_in),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .stall_pipe  (stall_pipe),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_r_in = 1'b0; mem_w_in = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; bus_rdata = '0; bus_ready = 1'b0;
    nxt(); nxt();

    // Reset state
    #1;
    chk1 ("rst_bus_req",   bus_req, 1'b0);
    chk1 ("rst_stall",     stall_pipe, 1'b0);
    chk32("rst_if_rdata",  if_rdata, 32'h0);
    chk32("rst_mem_rdata", mem_rdata, 32'h0);
    chk1 ("rst_timeout",   timeout_err, 1'b0);
    chk32("rst_bus_addr",  bus_addr, 32'h0);
    if_req = 1'b1; if_addr = 32'h0; bus_ready = 1'b1; bus_rdata = 32'h0000_0013;
    #1;
    chk1 ("rst_stall_comb", stall_pipe, 1'b1);
    chk1 ("rst_bus_req_hold", bus_req, 1'b0);
    chk32("rst_if_rdata_hold", if_rdata, 32'h0);
    nxt();

    // Single fetch, zero-wait bus
    rst = 1'b1;
    #1;
    chk1 ("f_c0_bus_req", bus_req, 1'b0);
    chk1 ("f_c0_stall",   stall_pipe, 1'b1);
    nxt(); #1;
    chk1 ("f_c1_bus_req", bus_req, 1'b1);
    chk1 ("f_c1_we",      bus_we, 1'b0);
    chk32("f_c1_addr",    bus_addr, 32'h0);
    chk32("f_c1_wstrb",   {28'h0, bus_wstrb}, 32'h0);
    chk32("f_c1_if_rdata", if_rdata, 32'h0000_0013);
    chk1 ("f_c1_stall",   stall_pipe, 1'b0);
    nxt(); if_req = 1'b0; bus_rdata = 32'h0000_0055; #1;
    chk1 ("f_c2_bus_req", bus_req, 1'b0);
    chk1 ("f_c2_stall",   stall_pipe, 1'b0);
    chk32("f_c2_if_rdata", if_rdata, 32'h0000_0013);

    // Load + fetch in one step
    nxt();
    mem_r_in = 1'b1; mem_addr = 32'h0000_0100; if_req = 1'b1; if_addr = 32'h0000_0004;
    bus_ready = 1'b1; bus_rdata = 32'hAAAA_0001; #1;
    chk1 ("lf_c0_bus_req", bus_req, 1'b0);
    chk1 ("lf_c0_stall",   stall_pipe, 1'b1);
    nxt(); #1;
    chk1 ("lf_c1_bus_req", bus_req, 1'b1);
    chk32("lf_c1_addr",    bus_addr, 32'h0000_0100);
    chk1 ("lf_c1_we",      bus_we, 1'b0);
    chk32("lf_c1_mem_rdata", mem_rdata, 32'hAAAA_0001);
    chk1 ("lf_c1_stall",   stall_pipe, 1'b1);
    nxt(); bus_rdata = 32'h0000_0093; #1;
    chk1 ("lf_c2_bus_req", bus_req, 1'b1);
    chk32("lf_c2_addr",    bus_addr, 32'h0000_0004);
    chk32("lf_c2_if_rdata", if_rdata, 32'h0000_0093);
    chk32("lf_c2_mem_rdata", mem_rdata, 32'hAAAA_0001);
    chk1 ("lf_c2_stall",   stall_pipe, 1'b0);
    nxt(); mem_r_in = 1'b0; if_req = 1'b0; #1;
    chk1 ("lf_c3_bus_req", bus_req, 1'b0);
    chk1 ("lf_c3_stall",   stall_pipe, 1'b0);
    chk32("lf_c3_if_rdata", if_rdata, 32'h0000_0093);

    // Store with three wait cycles; inputs disturbed mid-grant
    nxt();
    mem_w_in = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b0011;
    bus_ready = 1'b0; #1;
    chk1 ("st_c0_stall", stall_pipe, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 2) begin
        mem_addr = 32'hFFFF_FFFC; mem_wdata = 32'h0; mem_wstrb = 4'hF;
      end
      #1;
      chk1 ("st_wait_req",   bus_req, 1'b1);
      chk1 ("st_wait_we",    bus_we, 1'b1);
      chk32("st_wait_addr",  bus_addr, 32'h0000_0200);
      chk32("st_wait_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk32("st_wait_wstrb", {28'h0, bus_wstrb}, 32'h3);
      chk1 ("st_wait_stall", stall_pipe, 1'b1);
    end
    nxt(); bus_ready = 1'b1; #1;
    chk1 ("st_rdy_we",     bus_we, 1'b1);
    chk32("st_rdy_addr",   bus_addr, 32'h0000_0200);
    chk32("st_rdy_wdata",  bus_wdata, 32'hDEAD_BEEF);
    chk32("st_rdy_wstrb",  {28'h0, bus_wstrb}, 32'h3);
    chk1 ("st_rdy_stall",  stall_pipe, 1'b0);
    chk1 ("st_rdy_timeout", timeout_err, 1'b0);
    nxt(); mem_w_in = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0; #1;
    chk1 ("st_done_req",   bus_req, 1'b0);
    chk1 ("st_done_stall", stall_pipe, 1'b0);
    chk32("st_done_mem_rdata", mem_rdata, 32'hAAAA_0001);

    // Read and write together: treated as a write
    nxt();
    mem_r_in = 1'b1; mem_w_in = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h1234_5678;
    mem_wstrb = 4'hF; bus_ready = 1'b1; bus_rdata = 32'hBADB_AD00; #1;
    chk1 ("rw_c0_stall", stall_pipe, 1'b1);
    nxt(); #1;
    chk1 ("rw_c1_we",    bus_we, 1'b1);
    chk32("rw_c1_addr",  bus_addr, 32'h0000_0300);
    chk32("rw_c1_wdata", bus_wdata, 32'h1234_5678);
    chk32("rw_c1_wstrb", {28'h0, bus_wstrb}, 32'hF);
    chk1 ("rw_c1_stall", stall_pipe, 1'b0);
    nxt(); mem_r_in = 1'b0; mem_w_in = 1'b0; mem_wdata = 32'h0; mem_wstrb = 4'h0; bus_rdata = 32'h0; #1;
    chk1 ("rw_c2_req",   bus_req, 1'b0);
    chk32("rw_c2_mem_rdata", mem_rdata, 32'hAAAA_0001);

    // Timeout: ready held low for 20 grant cycles
    nxt();
    mem_r_in = 1'b1; mem_addr = 32'h0000_0400; bus_ready = 1'b0; #1;
    chk1 ("to_c0_stall",   stall_pipe, 1'b1);
    chk1 ("to_c0_timeout", timeout_err, 1'b0);
    for (int g = 1; g <= 20; g++) begin
      nxt(); #1;
      chk1("to_wait_req", bus_req, 1'b1);
      if (g == 15) chk1("to_g15_timeout", timeout_err, 1'b0);
      if (g == 16) chk1("to_g16_timeout", timeout_err, 1'b1);
    end
    nxt(); bus_ready = 1'b1; bus_rdata = 32'h7777_0000; #1;
    chk32("to_rdy_addr",      bus_addr, 32'h0000_0400);
    chk32("to_rdy_mem_rdata", mem_rdata, 32'h7777_0000);
    chk1 ("to_rdy_stall",     stall_pipe, 1'b0);
    chk1 ("to_rdy_timeout",   timeout_err, 1'b1);
    nxt(); mem_r_in = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0; #1;
    chk1 ("to_done_req",      bus_req, 1'b0);
    chk1 ("to_done_timeout",  timeout_err, 1'b1);
    chk32("to_done_mem_rdata", mem_rdata, 32'h7777_0000);

    // Reset in the middle of a MEM grant
    nxt();
    mem_r_in = 1'b1; mem_addr = 32'h0000_0500; bus_ready = 1'b0; #1;
    chk1 ("mr_c0_stall", stall_pipe, 1'b1);
    nxt(); #1;
    chk1 ("mr_c1_req",   bus_req, 1'b1);
    chk32("mr_c1_addr",  bus_addr, 32'h0000_0500);
    nxt(); #1;
    rst = 1'b0; #1;
    chk1 ("mr_rst_req",       bus_req, 1'b0);
    chk32("mr_rst_addr",      bus_addr, 32'h0);
    chk1 ("mr_rst_timeout",   timeout_err, 1'b0);
    chk32("mr_rst_mem_rdata", mem_rdata, 32'h0);
    chk1 ("mr_rst_stall",     stall_pipe, 1'b1);
    nxt(); nxt();
    rst = 1'b1; #1;
    chk1 ("mr_rel_req",   bus_req, 1'b0);
    chk1 ("mr_rel_stall", stall_pipe, 1'b1);
    nxt(); bus_ready = 1'b1; bus_rdata = 32'h00C0_FFEE; #1;
    chk1 ("mr_gnt_req",       bus_req, 1'b1);
    chk32("mr_gnt_addr",      bus_addr, 32'h0000_0500);
    chk32("mr_gnt_mem_rdata", mem_rdata, 32'h00C0_FFEE);
    chk1 ("mr_gnt_stall",     stall_pipe, 1'b0);
    chk1 ("mr_gnt_timeout",   timeout_err, 1'b0);
    nxt(); mem_r_in = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0; #1;
    chk1 ("mr_done_req",       bus_req, 1'b0);
    chk32("mr_done_mem_rdata", mem_rdata, 32'h00C0_FFEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
